// File: rtl/or1200_vlx_packer.sv
`default_nettype none
// ============================================================================
//  Module      : or1200_vlx_packer
//  Description : Packs right-aligned variable-length codes (1..16 bits) into
//                a byte stream, MSB first. Optional JPEG byte stuffing puts a
//                0x00 after every emitted 0xFF. A flush pads the last partial
//                byte with 1s, emits it, then pulses done_o. Each byte is
//                handed to a store unit with a pulse and held until ack_i.
//  Revision    : 1.0 - initial release
// ============================================================================
module or1200_vlx_packer #(
    parameter int STUFF_EN = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] code_i,
    input  logic [4:0]  len_i,
    input  logic        code_valid_i,
    output logic        code_ready_o,
    input  logic        flush_i,
    input  logic        ack_i,
    output logic        store_byte_o,
    output logic [7:0]  byte_o,
    output logic        done_o
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] c_top_mask = 32'hFF00_0000;

    state_t      state_q, state_d;
    logic [31:0] buf_q, buf_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        flush_pend_q, flush_pend_d;
    logic        stuff_pend_q, stuff_pend_d;
    logic        store_byte_q, store_byte_d;
    logic [7:0]  byte_q, byte_d;
    logic        done_q, done_d;

    logic [4:0]  w_len;
    logic [15:0] w_code_masked;
    logic [5:0]  w_shamt;
    logic [31:0] w_code_placed;
    logic [31:0] w_pad_mask;
    logic        w_xfer;

    // Clamp the length, mask the code and line it up just below the pending bits.
    // The shift is only meaningful while cnt < 8, which is the only time a
    // code can be accepted.
    assign w_len         = (len_i > 5'd16) ? 5'd16 : len_i;
    assign w_code_masked = code_i & ~(16'hFFFF << w_len);
    assign w_shamt       = 6'd32 - cnt_q - {1'b0, w_len};
    assign w_code_placed = {16'h0000, w_code_masked} << w_shamt;
    // Ones from the first free bit down to bit 24 complete the top byte.
    assign w_pad_mask    = (c_top_mask >> cnt_q) & c_top_mask;

    assign code_ready_o  = (state_q == S_RUN) && (cnt_q < 6'd8) && !flush_pend_q && !rst_i;
    assign w_xfer        = code_valid_i && code_ready_o;

    assign store_byte_o  = store_byte_q;
    assign byte_o        = byte_q;
    assign done_o        = done_q;

    // State register with synchronous reset that discards all pending data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_RUN;
            buf_q        <= 32'h0;
            cnt_q        <= 6'd0;
            flush_pend_q <= 1'b0;
            stuff_pend_q <= 1'b0;
            store_byte_q <= 1'b0;
            byte_q       <= 8'h00;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            stuff_pend_q <= stuff_pend_d;
            store_byte_q <= store_byte_d;
            byte_q       <= byte_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic: accept codes, emit full bytes, pad on flush, stuff after 0xFF.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q | flush_i;
        stuff_pend_d = stuff_pend_q;
        store_byte_d = 1'b0;
        byte_d       = byte_q;
        done_d       = 1'b0;

        case (state_q)
            S_RUN: begin
                if (w_xfer) begin
                    // A code and a flush in the same cycle: the code goes in
                    // first, the flush is served once it is buffered.
                    buf_d = buf_q | w_code_placed;
                    cnt_d = cnt_q + {1'b0, w_len};
                end else if (cnt_q >= 6'd8) begin
                    store_byte_d = 1'b1;
                    byte_d       = buf_q[31:24];
                    buf_d        = buf_q << 8;
                    cnt_d        = cnt_q - 6'd8;
                    stuff_pend_d = (STUFF_EN != 0) && (buf_q[31:24] == 8'hFF);
                    state_d      = S_WAIT;
                end else if (flush_pend_q && (cnt_q != 6'd0)) begin
                    buf_d = buf_q | w_pad_mask;
                    cnt_d = 6'd8;
                end else if (flush_pend_q) begin
                    done_d       = 1'b1;
                    flush_pend_d = flush_i;
                end
            end
            S_WAIT: begin
                if (ack_i) begin
                    if (stuff_pend_q) begin
                        // The stuffed zero is never itself a stuffing candidate.
                        store_byte_d = 1'b1;
                        byte_d       = 8'h00;
                        stuff_pend_d = 1'b0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_or1200_vlx_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_or1200_vlx_packer
//  Description : Self-checking bench for or1200_vlx_packer: directed vector
//                table, hand-written corner sequences, and random codes
//                checked against a bit-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_or1200_vlx_packer;

    localparam int c_DONE = 256;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] code_i;
    logic [4:0]  len_i;
    logic        code_valid_i, flush_i, ack_i;
    logic        code_ready_o, store_byte_o, done_o;
    logic [7:0]  byte_o;

    logic [15:0] code0;
    logic [4:0]  len0;
    logic        valid0, flush0, ack0;
    logic        ready0, store0, done0;
    logic [7:0]  byte0;

    always #5 clk = ~clk;

    or1200_vlx_packer #(.STUFF_EN(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .code_i(code_i), .len_i(len_i),
        .code_valid_i(code_valid_i), .code_ready_o(code_ready_o),
        .flush_i(flush_i), .ack_i(ack_i), .store_byte_o(store_byte_o),
        .byte_o(byte_o), .done_o(done_o)
    );

    or1200_vlx_packer #(.STUFF_EN(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .code_i(code0), .len_i(len0),
        .code_valid_i(valid0), .code_ready_o(ready0),
        .flush_i(flush0), .ack_i(ack0), .store_byte_o(store0),
        .byte_o(byte0), .done_o(done0)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit bits_q[$];
    bit model_on = 1'b0;
    bit ack_en   = 1'b1;
    int ack_fix  = 2;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // ---------------- reference model: plain bit queue ----------------
    function automatic void model_drain();
        int b;
        while (bits_q.size() >= 8) begin
            b = 0;
            for (int k = 0; k < 8; k++) b = (b << 1) | int'(bits_q.pop_front());
            exp_q.push_back(b);
            if (b == 255) exp_q.push_back(0);
        end
    endfunction

    function automatic void model_push(input logic [15:0] c, input logic [4:0] l);
        int le;
        le = (l > 5'd16) ? 16 : int'(l);
        for (int k = le - 1; k >= 0; k--) bits_q.push_back(c[k]);
        model_drain();
    endfunction

    function automatic void model_flush();
        while ((bits_q.size() % 8) != 0) bits_q.push_back(1'b1);
        model_drain();
        exp_q.push_back(c_DONE);
    endfunction

    // ---------------- monitor: every observed event is a check ----------------
    task automatic observe(input int v);
        int w;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got 0x%0h expected none", v);
        end else begin
            w = exp_q.pop_front();
            if (w != v) begin
                errors++;
                $display("FAIL event: got 0x%0h expected 0x%0h", v, w);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (store_byte_o) observe(int'(byte_o));
            if (done_o)       observe(c_DONE);
        end
    end

    // ---------------- store-unit responder ----------------
    initial begin
        int cd;
        cd    = -1;
        ack_i = 1'b0;
        forever begin
            @(negedge clk);
            ack_i = 1'b0;
            if (rst_i) begin
                cd = -1;
            end else begin
                if (store_byte_o) cd = (ack_fix < 0) ? int'($urandom_range(0, 3)) : ack_fix;
                else if (cd > 0) cd--;
                if (cd == 0 && ack_en) begin
                    ack_i = 1'b1;
                    cd    = -1;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        rst_i = 1'b1;
        code_valid_i = 1'b0; flush_i = 1'b0; valid0 = 1'b0; flush0 = 1'b0;
        exp_q.delete();
        bits_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst ready", int'(code_ready_o), 0);
        chk("rst store", int'(store_byte_o), 0);
        chk("rst done",  int'(done_o), 0);
        chk("rst byte",  int'(byte_o), 0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("ready after rst", int'(code_ready_o), 1);
    endtask

    task automatic send(input logic [15:0] c, input logic [4:0] l, input bit f);
        int n;
        code_i = c; len_i = l; code_valid_i = 1'b1; flush_i = 1'b0;
        n = 0;
        while (!code_ready_o && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("ready wait", int'(code_ready_o), 1);
        if (code_ready_o) begin
            flush_i = f;
            @(posedge clk);
            if (model_on) begin
                model_push(c, l);
                if (f) model_flush();
            end
            #1;
        end
        code_valid_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(posedge clk);
        if (model_on) model_flush();
        #1 flush_i = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk); n++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] c1;
        logic [4:0]  l1;
        logic [15:0] c2;
        logic [4:0]  l2;
        int          fl;   // 0 none, 1 flush after codes, 2 flush with first code
        int          n;
        int          ev[6];
    } vec_t;

    vec_t vecs[9];

    task automatic set_vec(input int i, input logic [15:0] c1, input logic [4:0] l1,
                           input logic [15:0] c2, input logic [4:0] l2, input int fl,
                           input int n, input int e0, input int e1, input int e2,
                           input int e3, input int e4);
        vecs[i].c1 = c1; vecs[i].l1 = l1; vecs[i].c2 = c2; vecs[i].l2 = l2;
        vecs[i].fl = fl; vecs[i].n = n;
        vecs[i].ev[0] = e0; vecs[i].ev[1] = e1; vecs[i].ev[2] = e2;
        vecs[i].ev[3] = e3; vecs[i].ev[4] = e4; vecs[i].ev[5] = 0;
    endtask

    initial begin
        int cnt0, last0, done0_seen, lat_start;
        rst_i = 1'b1; code_i = '0; len_i = '0; code_valid_i = 1'b0; flush_i = 1'b0;
        code0 = '0; len0 = '0; valid0 = 1'b0; flush0 = 1'b0; ack0 = 1'b1;

        set_vec(0, 16'hABCD, 5'd16, 16'h0000, 5'd0, 0, 2, 'hAB, 'hCD, 0, 0, 0);
        set_vec(1, 16'h0003, 5'd2,  16'h0000, 5'd6, 0, 1, 'hC0, 0, 0, 0, 0);
        set_vec(2, 16'h0005, 5'd3,  16'h0000, 5'd0, 1, 2, 'hBF, c_DONE, 0, 0, 0);
        set_vec(3, 16'h00FF, 5'd8,  16'h0000, 5'd0, 0, 2, 'hFF, 'h00, 0, 0, 0);
        set_vec(4, 16'h0000, 5'd0,  16'h0000, 5'd0, 1, 1, c_DONE, 0, 0, 0, 0);
        set_vec(5, 16'h0001, 5'd1,  16'h0000, 5'd0, 2, 3, 'hFF, 'h00, c_DONE, 0, 0);
        set_vec(6, 16'h1234, 5'd31, 16'h0000, 5'd0, 0, 2, 'h12, 'h34, 0, 0, 0);
        set_vec(7, 16'h01FF, 5'd9,  16'h0000, 5'd0, 1, 5, 'hFF, 'h00, 'hFF, 'h00, c_DONE);
        set_vec(8, 16'hFFE3, 5'd5,  16'h0005, 5'd3, 0, 1, 'h1D, 0, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            ack_fix = 2;
            for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].ev[k]);
            send(vecs[i].c1, vecs[i].l1, vecs[i].fl == 2);
            if (vecs[i].l2 != 5'd0) send(vecs[i].c2, vecs[i].l2, 1'b0);
            if (vecs[i].fl == 1) do_flush();
            wait_empty("vector drain");
            repeat (10) @(negedge clk);
        end

        // Latency: transfer at E0, pulse visible after E0+1.
        do_reset();
        exp_q.push_back('hAB); exp_q.push_back('hCD);
        code_i = 16'hABCD; len_i = 5'd16; code_valid_i = 1'b1;
        @(posedge clk);
        #1 code_valid_i = 1'b0;
        @(negedge clk);
        lat_start = int'(store_byte_o);
        chk("latency E0", lat_start, 0);
        @(negedge clk);
        chk("latency E1", int'(store_byte_o), 1);
        wait_empty("latency drain");

        // Reset while waiting for ack with a stuffed zero pending.
        ack_en = 1'b0;
        do_reset();
        exp_q.push_back('hFF);
        send(16'h00FF, 5'd8, 1'b0);
        wait_empty("pre-reset byte");
        repeat (3) @(negedge clk);
        chk("stall ready", int'(code_ready_o), 0);
        do_reset();
        ack_en = 1'b1;
        repeat (20) @(negedge clk);
        exp_q.push_back('hFF); exp_q.push_back('h00); exp_q.push_back(c_DONE);
        send(16'h0003, 5'd2, 1'b1);
        wait_empty("post-reset flush");

        // Stuffing disabled instance emits 0xFF alone.
        do_reset();
        chk("s0 ready", int'(ready0), 1);
        code0 = 16'h00FF; len0 = 5'd8; valid0 = 1'b1;
        @(posedge clk);
        #1 valid0 = 1'b0;
        cnt0 = 0; last0 = 0; done0_seen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (store0) begin cnt0++; last0 = int'(byte0); end
            if (done0) done0_seen++;
        end
        chk("s0 pulses", cnt0, 1);
        chk("s0 byte", last0, 'hFF);
        chk("s0 done", done0_seen, 0);
        chk("s0 ready back", int'(ready0), 1);

        // Random codes against the bit-queue model.
        do_reset();
        model_on = 1'b1;
        ack_fix  = -1;
        for (int it = 0; it < 400; it++) begin
            int r;
            bit f;
            r = int'($urandom_range(0, 99));
            if (r < 75) begin
                f = ($urandom_range(0, 9) == 0);
                send(16'($urandom), 5'($urandom_range(0, 20)), f);
                if (f) wait_empty("rand flush drain");
            end else if (r < 85) begin
                do_flush();
                wait_empty("rand flush drain");
            end else begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        do_flush();
        wait_empty("final drain");
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/or1200_vlx_packer.md
OR1200_VLX_PACKER -- requirements
Module: or1200_vlx_packer

Interface
REQ-001 Parameter STUFF_EN, default 1, meaning: 1 = insert 0x00 after every emitted 0xFF byte (JPEG byte stuffing); 0 = no stuffing.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 code_i  input  16  variable-length code; only the low len_i bits are used, right-aligned, MSB emitted first.
REQ-005 len_i  input  5  code length in bits; 0 = no-op, 1..16 valid, 17..31 treated as 16.
REQ-006 code_valid_i  input  1  code_i/len_i valid this cycle.
REQ-007 code_ready_o  output  1  packer accepts a code this cycle; a code transfers when code_valid_i && code_ready_o.
REQ-008 flush_i  input  1  one-cycle request to pad and emit remaining bits.
REQ-009 ack_i  input  1  downstream store unit reports the current byte written.
REQ-010 store_byte_o  output  1  one-cycle pulse: byte_o is a new byte to store.
REQ-011 byte_o  output  8  byte to store; stable from the store_byte_o pulse until ack_i.
REQ-012 done_o  output  1  one-cycle pulse: flush completed, no bits pending.

Function
REQ-013 Internal state: 32-bit MSB-aligned bit buffer buf, 6-bit count cnt (0..23), flush_pend flag, stuff_pend flag, FSM states S_RUN, S_WAIT.
REQ-014 code_ready_o SHALL be combinational: 1 iff state==S_RUN && cnt<8 && !flush_pend && !rst_i.
REQ-015 On code transfer: masked code placed at buf[31-cnt -: len], bits below it unchanged/zero, cnt <= cnt+len (len clamped per REQ-005); len 0 leaves buf/cnt unchanged.
REQ-016 flush_i high in any cycle sets flush_pend; flush_i coincident with a code transfer accepts the code first, flush honoured afterwards.
REQ-017 S_RUN, cnt>=8: at the edge, store_byte_o<=1, byte_o<=buf[31:24], buf<<=8, cnt-=8, stuff_pend<=(STUFF_EN && buf[31:24]==8'hFF), go S_WAIT.
REQ-018 S_RUN, cnt<8, flush_pend, cnt>0: buf bits [31-cnt:24] filled with 1s, cnt<=8; no byte emitted this edge; emission follows per REQ-017.
REQ-019 S_RUN, cnt==0, flush_pend: done_o<=1 for one cycle, flush_pend<=0, stay S_RUN.
REQ-020 store_byte_o and done_o SHALL be registered and cleared at the edge after being set.
REQ-021 S_WAIT: ack_i ignored until sampled high; on ack with stuff_pend: store_byte_o<=1, byte_o<=8'h00, stuff_pend<=0, stay S_WAIT; on ack without stuff_pend: go S_RUN.
REQ-022 ack_i in S_RUN SHALL be ignored; ack_i in the same cycle as the store_byte_o pulse SHALL be accepted.
REQ-023 Stuffed 0x00 SHALL NOT itself be checked for stuffing; bytes leave strictly in bit order.
REQ-024 Latency: code transferred at edge E0 with resulting cnt>=8 yields store_byte_o high in the cycle following edge E0+1.
REQ-025 cnt SHALL never exceed 23; no bits dropped or duplicated for any legal input sequence.

Reset
REQ-026 At a clock edge with rst_i high: state S_RUN, buf=0, cnt=0, flush_pend=0, stuff_pend=0, store_byte_o=0, byte_o=0, done_o=0.
REQ-027 Reset mid-operation (including in S_WAIT or with stuff pending) SHALL discard all pending bits and bytes with no further store_byte_o pulses.
REQ-028 code_ready_o SHALL be 0 while rst_i is high.

Verification
REQ-029 code 0xABCD len 16, ack 2 cycles after each pulse -> bytes 0xAB then 0xCD, no done_o.
REQ-030 code 0x3 len 2, then code 0x00 len 6 -> single byte 0xC0.
REQ-031 code 0x5 len 3, then flush_i -> byte 0xBF (101 padded with 11111), then done_o pulse, cnt 0.
REQ-032 STUFF_EN=1, code 0xFF len 8 -> byte 0xFF, after ack byte 0x00, after ack return to S_RUN; STUFF_EN=0 -> 0xFF only.
REQ-033 flush_i with cnt 0 -> done_o pulse next edge, no store_byte_o; flush_i coincident with code 0x1 len 1 -> byte 0xFF then done_o.
REQ-034 rst_i asserted in S_WAIT with stuff pending -> no further pulses, code_ready_o 1 the cycle after rst_i falls, cnt 0.
